// File: rtl/seven_segment_to_binary.sv
// seven_segment_to_binary: debounces a 7-segment bus and decodes stable patterns back to hex
module seven_segment_to_binary #(
    parameter int STABLE_COUNT = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Segment_A,
    input  logic       i_Segment_B,
    input  logic       i_Segment_C,
    input  logic       i_Segment_D,
    input  logic       i_Segment_E,
    input  logic       i_Segment_F,
    input  logic       i_Segment_G,
    input  logic       i_Digit_Enable,
    output logic [3:0] o_Binary_Num,
    output logic       o_DV,
    output logic       o_Error,
    output logic       o_Blank,
    output logic       o_Locked
);
    typedef enum logic {S_COUNT, S_LOCKED} state_t;
    state_t     r_State, next_state;
    logic [6:0] r_Seg, r_Cand, r_Last, next_cand, last_d;
    logic [7:0] r_Count, next_count;
    logic       r_En, r_Last_Vld, last_vld_d;
    logic       new_pat, same_pat, hit, accept;
    logic [3:0] dec_val, bin_d;
    logic       dec_vld, dec_blank, dv_d, err_d, blank_d, locked_d;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Seg <= '0;
            r_En  <= 1'b0;
        end else begin
            r_Seg <= {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                      i_Segment_E, i_Segment_F, i_Segment_G};
            r_En  <= i_Digit_Enable;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State      <= S_COUNT;
            r_Cand       <= '0;
            r_Count      <= '0;
            r_Last       <= '0;
            r_Last_Vld   <= 1'b0;
            o_Binary_Num <= '0;
            o_DV         <= 1'b0;
            o_Error      <= 1'b0;
            o_Blank      <= 1'b0;
            o_Locked     <= 1'b0;
        end else begin
            r_State      <= next_state;
            r_Cand       <= next_cand;
            r_Count      <= next_count;
            r_Last       <= last_d;
            r_Last_Vld   <= last_vld_d;
            o_Binary_Num <= bin_d;
            o_DV         <= dv_d;
            o_Error      <= err_d;
            o_Blank      <= blank_d;
            o_Locked     <= locked_d;
        end
    end

    // On any accepting edge the accepted pattern equals r_Seg, so decode r_Seg directly
    always_comb begin
        new_pat    = r_En && (r_Seg != r_Cand);
        same_pat   = r_En && (r_Seg == r_Cand) && (r_State == S_COUNT);
        hit        = ({1'b0, r_Count} + 9'd1) == 9'(STABLE_COUNT);
        accept     = new_pat ? (STABLE_COUNT == 1) : (same_pat && hit);
        next_state = accept ? S_LOCKED : new_pat ? S_COUNT : r_State;
        next_cand  = new_pat ? r_Seg : r_Cand;
        next_count = new_pat ? 8'd1 : (same_pat && r_Count != 8'hFF) ? r_Count + 8'd1 : r_Count;
    end

    always_comb begin
        dec_val   = 4'h0;
        dec_vld   = 1'b1;
        dec_blank = (r_Seg == 7'h00);
        case (r_Seg)
            7'h7E: dec_val = 4'h0;
            7'h30: dec_val = 4'h1;
            7'h6D: dec_val = 4'h2;
            7'h79: dec_val = 4'h3;
            7'h33: dec_val = 4'h4;
            7'h5B: dec_val = 4'h5;
            7'h5F: dec_val = 4'h6;
            7'h70: dec_val = 4'h7;
            7'h7F: dec_val = 4'h8;
            7'h7B: dec_val = 4'h9;
            7'h77: dec_val = 4'hA;
            7'h1F: dec_val = 4'hB;
            7'h4E: dec_val = 4'hC;
            7'h3D: dec_val = 4'hD;
            7'h4F: dec_val = 4'hE;
            7'h47: dec_val = 4'hF;
            default: dec_vld = 1'b0;
        endcase
    end

    // Re-accepting the last valid digit (e.g. after a glitch) stays silent
    always_comb begin
        dv_d       = accept && dec_vld && ((r_Seg != r_Last) || !r_Last_Vld);
        err_d      = accept && !dec_vld && !dec_blank;
        bin_d      = (accept && dec_vld) ? dec_val : o_Binary_Num;
        blank_d    = accept ? dec_blank : o_Blank;
        locked_d   = accept ? 1'b1 : new_pat ? 1'b0 : o_Locked;
        last_d     = accept ? r_Seg : r_Last;
        last_vld_d = r_Last_Vld || (accept && dec_vld);
    end
endmodule

// File: tb/tb_seven_segment_to_binary.sv
// tb_seven_segment_to_binary: directed checks of decode, filtering, glitch, enable and reset behaviour
module tb_seven_segment_to_binary;
    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic [6:0] seg = '0;
    logic       en = 1'b0;
    logic [3:0] o_Binary_Num;
    logic       o_DV, o_Error, o_Blank, o_Locked;
    int         vectors = 0, miscompares = 0;
    int         dv_cnt = 0, err_cnt = 0, conflicts = 0;
    int         dv0, err0;
    logic [6:0] table_pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                   7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    seven_segment_to_binary #(.STABLE_COUNT(4)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst),
        .i_Segment_A(seg[6]), .i_Segment_B(seg[5]), .i_Segment_C(seg[4]), .i_Segment_D(seg[3]),
        .i_Segment_E(seg[2]), .i_Segment_F(seg[1]), .i_Segment_G(seg[0]),
        .i_Digit_Enable(en),
        .o_Binary_Num(o_Binary_Num), .o_DV(o_DV), .o_Error(o_Error),
        .o_Blank(o_Blank), .o_Locked(o_Locked)
    );

    always #5 i_Clk = ~i_Clk;

    always @(negedge i_Clk) begin
        if (o_DV) dv_cnt++;
        if (o_Error) err_cnt++;
        if (o_DV && o_Error) conflicts++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_Clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        step(2);
        check("rst_bin", 32'(o_Binary_Num), 0);
        check("rst_dv", 32'(o_DV), 0);
        check("rst_err", 32'(o_Error), 0);
        check("rst_blank", 32'(o_Blank), 0);
        check("rst_locked", 32'(o_Locked), 0);
        // 1: hold 0x6D, accept on edge 5
        i_Rst = 1'b0; seg = 7'h6D; en = 1'b1;
        dv0 = dv_cnt;
        step(4);
        check("t1_dv_edge4", 32'(o_DV), 0);
        check("t1_locked_edge4", 32'(o_Locked), 0);
        step(1);
        check("t1_dv_edge5", 32'(o_DV), 1);
        check("t1_bin", 32'(o_Binary_Num), 2);
        check("t1_locked", 32'(o_Locked), 1);
        step(1);
        check("t1_dv_edge6", 32'(o_DV), 0);
        step(6);
        check("t1_dv_total", 32'(dv_cnt - dv0), 1);
        // 2: sweep all table patterns
        dv0 = dv_cnt; err0 = err_cnt;
        for (int i = 0; i < 16; i++) begin
            seg = table_pat[i];
            step(8);
            check($sformatf("t2_bin_%0d", i), 32'(o_Binary_Num), 32'(i));
        end
        check("t2_dv_total", 32'(dv_cnt - dv0), 16);
        check("t2_err_total", 32'(err_cnt - err0), 0);
        // 3: glitch on a held 3
        seg = 7'h79;
        step(8);
        check("t3_bin_pre", 32'(o_Binary_Num), 3);
        dv0 = dv_cnt;
        seg = 7'h7F;
        step(2);
        check("t3_locked_glitch", 32'(o_Locked), 0);
        seg = 7'h79;
        step(8);
        check("t3_locked_after", 32'(o_Locked), 1);
        check("t3_bin_after", 32'(o_Binary_Num), 3);
        check("t3_dv_none", 32'(dv_cnt - dv0), 0);
        // 4: invalid pattern
        err0 = err_cnt; dv0 = dv_cnt;
        seg = 7'h01;
        step(6);
        check("t4_err_once", 32'(err_cnt - err0), 1);
        check("t4_dv_none", 32'(dv_cnt - dv0), 0);
        check("t4_bin", 32'(o_Binary_Num), 3);
        check("t4_blank", 32'(o_Blank), 0);
        // 5: enable toggling, then blank
        dv0 = dv_cnt;
        seg = 7'h30;
        for (int i = 0; i < 7; i++) begin
            en = (i % 2 == 0);
            step(1);
        end
        check("t5_dv_early", 32'(dv_cnt - dv0), 0);
        check("t5_bin_early", 32'(o_Binary_Num), 3);
        for (int i = 7; i < 10; i++) begin
            en = (i % 2 == 0);
            step(1);
        end
        check("t5_dv_once", 32'(dv_cnt - dv0), 1);
        check("t5_bin", 32'(o_Binary_Num), 1);
        en = 1'b1; seg = 7'h00; dv0 = dv_cnt; err0 = err_cnt;
        step(8);
        check("t5_blank", 32'(o_Blank), 1);
        check("t5_blank_bin", 32'(o_Binary_Num), 1);
        check("t5_blank_dv", 32'(dv_cnt - dv0), 0);
        check("t5_blank_err", 32'(err_cnt - err0), 0);
        // 6: reset mid-count, then full re-acceptance
        seg = 7'h5B;
        step(4);
        i_Rst = 1'b1;
        step(1);
        check("t6_rst_bin", 32'(o_Binary_Num), 0);
        check("t6_rst_blank", 32'(o_Blank), 0);
        check("t6_rst_locked", 32'(o_Locked), 0);
        check("t6_rst_dv", 32'(o_DV), 0);
        i_Rst = 1'b0;
        step(4);
        check("t6_dv_early", 32'(o_DV), 0);
        step(1);
        check("t6_dv", 32'(o_DV), 1);
        check("t6_bin", 32'(o_Binary_Num), 5);
        check("dv_err_overlap", 32'(conflicts), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seven_segment_to_binary.md
Name: seven_segment_to_binary

Overview:
Inverse of the team's binary-to-7-segment encoder. The block samples a 7-segment drive bus (segments A..G, active-high) and filters it for stability. It decodes each stable pattern back to a 4-bit hex value and reports changes with a one-cycle data-valid strobe. Uses: loopback checking of display drivers, and reading segment outputs from external display controllers into the Go board fabric.

Parameters:
STABLE_COUNT, 4, number of consecutive identical enabled samples required to accept a pattern; legal range 1..255.

Ports:
i_Clk  input  1  system clock; all logic on rising edge.
i_Rst  input  1  synchronous, active-high reset.
i_Segment_A  input  1  segment A (top).
i_Segment_B  input  1  segment B.
i_Segment_C  input  1  segment C.
i_Segment_D  input  1  segment D.
i_Segment_E  input  1  segment E.
i_Segment_F  input  1  segment F.
i_Segment_G  input  1  segment G (middle).
i_Digit_Enable  input  1  sample qualifier; segments are ignored when low (multiplexed scan).
o_Binary_Num  output  4  last accepted valid digit.
o_DV  output  1  one-cycle pulse: new valid digit accepted.
o_Error  output  1  one-cycle pulse: stable pattern not in decode table and not blank.
o_Blank  output  1  level: last accepted pattern was all-zero.
o_Locked  output  1  level: current candidate has been accepted and is still present.

Behaviour:
- Pattern vector P = {A,B,C,D,E,F,G}, A = bit 6, G = bit 0.
- Input stage: P and i_Digit_Enable are registered every cycle (r_Seg, r_En). All further logic uses the registered copies.
- Decode table: 0x7E=0, 0x30=1, 0x6D=2, 0x79=3, 0x33=4, 0x5B=5, 0x5F=6, 0x70=7, 0x7F=8, 0x7B=9, 0x77=A, 0x1F=b, 0x4E=C, 0x3D=d, 0x4F=E, 0x47=F. Pattern 0x00 is blank. Every other pattern is invalid.
- Candidate tracker: r_Cand (7b), r_Count (8b), state in {S_COUNT, S_LOCKED}.
- When r_En = 0: all tracker state holds, and no pulses are generated.
- When r_En = 1 and r_Seg != r_Cand: r_Cand <= r_Seg, r_Count <= 1, state <= S_COUNT, o_Locked <= 0. If STABLE_COUNT == 1, the pattern is accepted on this same edge.
- When r_En = 1, r_Seg == r_Cand and state is S_COUNT: r_Count increments. The pattern is accepted on the edge where r_Count + 1 == STABLE_COUNT.
- When r_En = 1, r_Seg == r_Cand and state is S_LOCKED: no action. The counter saturates and does not wrap.
- Acceptance: state <= S_LOCKED, o_Locked <= 1, r_Last <= r_Cand. Outputs then update by pattern type:
  - Valid pattern: o_Binary_Num <= decoded value, o_Blank <= 0. o_DV pulses only if r_Cand != r_Last or r_Last_Vld == 0. r_Last_Vld <= 1.
  - Blank pattern: o_Blank <= 1. o_Binary_Num holds. No pulse.
  - Invalid pattern: o_Error pulses. o_Blank <= 0. o_Binary_Num holds.
- Glitch rule: A stable, then B for fewer than STABLE_COUNT samples, then A again → A is re-accepted and o_DV does NOT pulse again, because r_Last == A.
- Latency: pattern held with enable high from input edge N → outputs update on edge N + STABLE_COUNT + 1. That is 1 edge for the input register plus STABLE_COUNT samples.
- o_DV and o_Error are never high in the same cycle. Each is high for exactly one cycle per acceptance.
- Reset (any cycle, including mid-count): o_Binary_Num = 0, o_DV = 0, o_Error = 0, o_Blank = 0, o_Locked = 0, r_Cand = 0x00, r_Count = 0, state = S_COUNT, r_Last_Vld = 0, input registers cleared. After reset, a held blank bus is accepted as blank after STABLE_COUNT enabled samples.

Test Plan:
1. Reset, then hold P=0x6D with enable=1 (STABLE_COUNT=4) → o_DV pulses once on edge 5 after the pattern is applied; o_Binary_Num=2 and o_Locked=1 thereafter; no further pulses while held.
2. Sweep all 16 table patterns, each held 8 cycles → 16 o_DV pulses, with o_Binary_Num = 0..F in order and o_Error never high.
3. Hold 0x79 (3), inject 0x7F for 2 cycles, return to 0x79 → o_Binary_Num stays 3, no o_DV, o_Locked drops during the glitch and re-asserts.
4. Hold invalid 0x01 for 6 cycles → single o_Error pulse; o_Binary_Num unchanged; o_Blank=0.
5. Toggle enable 1/0 every cycle while holding 0x30 → acceptance after 4 enabled samples (about 8 cycles); o_DV once, o_Binary_Num=1. Then hold 0x00 → o_Blank=1, no pulse.
6. Assert i_Rst on the cycle r_Count=3 while 0x5B is counting → all outputs 0 on the next edge; release reset with 0x5B held → o_DV after a full STABLE_COUNT+1 edges with o_Binary_Num=5.
